// File: rtl/puck_pkg.sv
// puck_pkg: shared widths, types and small helpers for the puck physics controller.
package puck_pkg;

  localparam int VEL_W = 5;          // signed velocity per axis, -15..+15
  localparam int POS_W = 13;         // signed position / delta arithmetic
  localparam int D2_W  = 2 * POS_W;  // squared-distance width

  typedef enum logic [2:0] {
    S_IDLE,
    S_COL1,
    S_COL2,
    S_FRIC,
    S_MOVE,
    S_WALL
  } puck_state_e;

  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [POS_W-1:0] pos_t;
  typedef logic        [D2_W-1:0]  dist2_t;

  // Velocity after a hit: direction follows the sign of the delta; a zero delta keeps the
  // current direction, with a stationary axis defaulting to positive.
  function automatic vel_t hit_vel(input pos_t delta, input vel_t cur, input vel_t speed);
    if (delta == '0) begin
      return cur[VEL_W-1] ? -speed : speed;
    end
    return delta[POS_W-1] ? -speed : speed;
  endfunction

  // One friction step: move a nonzero velocity one unit toward zero.
  function automatic vel_t toward_zero(input vel_t v);
    if (v == '0) begin
      return v;
    end
    return v[VEL_W-1] ? v + vel_t'(1) : v - vel_t'(1);
  endfunction

  function automatic vel_t abs_vel(input vel_t v);
    return v[VEL_W-1] ? -v : v;
  endfunction

  // Score counter step that saturates at 9.
  function automatic logic [3:0] sat_inc9(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

endpackage

// File: rtl/puck_dist2.sv
// puck_dist2: squared distance dx^2+dy^2 using a single shared squarer over two cycles.
// Phase 0 squares dx into a holding register; phase 1 squares dy and registers the sum.
module puck_dist2
  import puck_pkg::*;
(
  input  logic   clk_in,
  input  logic   rst,
  input  logic   en_i,
  input  logic   phase_i,
  input  pos_t   dx_i,
  input  pos_t   dy_i,
  output dist2_t d2_o
);

  pos_t                   op;
  logic signed [D2_W-1:0] prod;
  dist2_t                 sq_x_q;
  dist2_t                 d2_q;

  assign op   = phase_i ? dy_i : dx_i;
  assign prod = D2_W'(op) * D2_W'(op);

  // Two-cycle accumulate: first square held, second square added and registered
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sq_x_q <= '0;
      d2_q   <= '0;
    end else if (en_i) begin
      if (!phase_i) begin
        sq_x_q <= $unsigned(prod);
      end else begin
        d2_q <= sq_x_q + $unsigned(prod);
      end
    end
  end

  assign d2_o = d2_q;

endmodule

// File: rtl/puck_ctl.sv
// puck_ctl: per-frame air-hockey puck physics. On each vblank rising edge it runs player
// collision (P1 then P2), friction, move and wall bounce, then publishes the new position.
// Optional goal detection is enabled by defining GOAL_DETECT_EN.
module puck_ctl
  import puck_pkg::*;
#(
  parameter int FIELD_W   = 1024,
  parameter int FIELD_H   = 768,
  parameter int PUCK_R    = 16,
  parameter int START_X   = 512,
  parameter int START_Y   = 384,
  parameter int HIT_SPEED = 6,
  parameter int FRIC_DIV  = 16
`ifdef GOAL_DETECT_EN
  ,
  parameter int GOAL_Y_MIN = 284,
  parameter int GOAL_Y_MAX = 484
`endif
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic [11:0] p1_xpos_in,
  input  logic [11:0] p1_ypos_in,
  input  logic [7:0]  p1_radius_in,
  input  logic [11:0] p2_xpos_in,
  input  logic [11:0] p2_ypos_in,
  input  logic [7:0]  p2_radius_in,
  output logic [11:0] puck_xpos_out,
  output logic [11:0] puck_ypos_out,
  output logic [7:0]  puck_radius_out,
  output logic        busy_out,
  output logic        hit_out,
  output logic        goal_out,
  output logic [3:0]  score_p1_out,
  output logic [3:0]  score_p2_out
);

  localparam pos_t        X_MIN     = pos_t'(PUCK_R);
  localparam pos_t        X_MAX     = pos_t'(FIELD_W - 1 - PUCK_R);
  localparam pos_t        Y_MIN     = pos_t'(PUCK_R);
  localparam pos_t        Y_MAX     = pos_t'(FIELD_H - 1 - PUCK_R);
  localparam pos_t        X0        = pos_t'(START_X);
  localparam pos_t        Y0        = pos_t'(START_Y);
  localparam vel_t        HIT_V     = vel_t'(HIT_SPEED);
  localparam logic [15:0] FRIC_LAST = 16'(FRIC_DIV - 1);
  localparam dist2_t      R_PUCK    = dist2_t'(PUCK_R);
`ifdef GOAL_DETECT_EN
  localparam pos_t        GOAL_LO   = pos_t'(GOAL_Y_MIN);
  localparam pos_t        GOAL_HI   = pos_t'(GOAL_Y_MAX);
`endif

  puck_state_e state_q;
  logic        phase_q;
  logic        vblnk_q;
  pos_t        x_q, y_q;
  vel_t        vx_q, vy_q;
  logic [15:0] fric_q;
  logic        hit1_q;
  logic [11:0] xo_q, yo_q;
  logic        busy_q, hit_q, goal_q;
  logic [3:0]  score_p1_q, score_p2_q;

  logic   trigger;
  pos_t   dx1, dy1, dx2, dy2;
  logic   dist_en;
  dist2_t d2;
  dist2_t rsum1, rsum2, thr1, thr2;
  logic   p1_hit, p2_hit;
  pos_t   wall_x, wall_y;
  vel_t   wall_vx, wall_vy;
  logic   goal_p1, goal_p2;

  assign trigger = vblnk_in & ~vblnk_q;

  // Puck-minus-player deltas; both players kept live so P1's deltas are still valid when its
  // distance result arrives while the squarer is already working on P2.
  assign dx1 = x_q - pos_t'({1'b0, p1_xpos_in});
  assign dy1 = y_q - pos_t'({1'b0, p1_ypos_in});
  assign dx2 = x_q - pos_t'({1'b0, p2_xpos_in});
  assign dy2 = y_q - pos_t'({1'b0, p2_ypos_in});

  assign dist_en = (state_q == S_COL1) || (state_q == S_COL2);

  puck_dist2 u_dist2 (
    .clk_in  (clk_in),
    .rst     (rst),
    .en_i    (dist_en),
    .phase_i (phase_q),
    .dx_i    ((state_q == S_COL2) ? dx2 : dx1),
    .dy_i    ((state_q == S_COL2) ? dy2 : dy1),
    .d2_o    (d2)
  );

  assign rsum1  = dist2_t'(p1_radius_in) + R_PUCK;
  assign rsum2  = dist2_t'(p2_radius_in) + R_PUCK;
  assign thr1   = rsum1 * rsum1;
  assign thr2   = rsum2 * rsum2;
  // P1's distance is ready at the start of COL2, P2's at FRIC
  assign p1_hit = (d2 <= thr1);
  assign p2_hit = (d2 <= thr2);

  // Wall / goal resolution of the post-move position; both axes resolved together
  always_comb begin
    wall_x  = x_q;
    wall_y  = y_q;
    wall_vx = vx_q;
    wall_vy = vy_q;
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;
    if (x_q < X_MIN) begin
      wall_x  = X_MIN;
      wall_vx = abs_vel(vx_q);
    end else if (x_q > X_MAX) begin
      wall_x  = X_MAX;
      wall_vx = -abs_vel(vx_q);
    end
    if (y_q < Y_MIN) begin
      wall_y  = Y_MIN;
      wall_vy = abs_vel(vy_q);
    end else if (y_q > Y_MAX) begin
      wall_y  = Y_MAX;
      wall_vy = -abs_vel(vy_q);
    end
`ifdef GOAL_DETECT_EN
    if ((y_q >= GOAL_LO) && (y_q <= GOAL_HI)) begin
      goal_p2 = (x_q < X_MIN);
      goal_p1 = (x_q > X_MAX);
    end
`endif
  end

  // Update sequencer: one pass per frame, outputs published only in WALL
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      vblnk_q    <= 1'b0;
      x_q        <= X0;
      y_q        <= Y0;
      vx_q       <= '0;
      vy_q       <= '0;
      fric_q     <= '0;
      hit1_q     <= 1'b0;
      xo_q       <= 12'(START_X);
      yo_q       <= 12'(START_Y);
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      goal_q     <= 1'b0;
      score_p1_q <= '0;
      score_p2_q <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      hit_q   <= 1'b0;
      goal_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q <= S_COL1;
            phase_q <= 1'b0;
            busy_q  <= 1'b1;
            hit1_q  <= 1'b0;
          end
        end
        S_COL1: begin
          phase_q <= ~phase_q;
          if (phase_q) begin
            state_q <= S_COL2;
          end
        end
        S_COL2: begin
          phase_q <= ~phase_q;
          if (!phase_q && p1_hit) begin
            vx_q   <= hit_vel(dx1, vx_q, HIT_V);
            vy_q   <= hit_vel(dy1, vy_q, HIT_V);
            hit1_q <= 1'b1;
            hit_q  <= 1'b1;
          end
          if (phase_q) begin
            state_q <= S_FRIC;
          end
        end
        S_FRIC: begin
          // A P1 hit suppresses both P2 and friction; a P2 hit suppresses friction
          if (!hit1_q) begin
            if (p2_hit) begin
              vx_q  <= hit_vel(dx2, vx_q, HIT_V);
              vy_q  <= hit_vel(dy2, vy_q, HIT_V);
              hit_q <= 1'b1;
            end else if (fric_q == FRIC_LAST) begin
              fric_q <= '0;
              vx_q   <= toward_zero(vx_q);
              vy_q   <= toward_zero(vy_q);
            end else begin
              fric_q <= fric_q + 16'd1;
            end
          end
          state_q <= S_MOVE;
        end
        S_MOVE: begin
          x_q     <= x_q + pos_t'(vx_q);
          y_q     <= y_q + pos_t'(vy_q);
          state_q <= S_WALL;
        end
        S_WALL: begin
          if (goal_p1 || goal_p2) begin
            x_q    <= X0;
            y_q    <= Y0;
            vx_q   <= '0;
            vy_q   <= '0;
            xo_q   <= 12'(START_X);
            yo_q   <= 12'(START_Y);
            goal_q <= 1'b1;
            if (goal_p1) begin
              score_p1_q <= sat_inc9(score_p1_q);
            end else begin
              score_p2_q <= sat_inc9(score_p2_q);
            end
          end else begin
            x_q  <= wall_x;
            y_q  <= wall_y;
            vx_q <= wall_vx;
            vy_q <= wall_vy;
            xo_q <= wall_x[11:0];
            yo_q <= wall_y[11:0];
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign puck_xpos_out   = xo_q;
  assign puck_ypos_out   = yo_q;
  assign puck_radius_out = 8'(PUCK_R);
  assign busy_out        = busy_q;
  assign hit_out         = hit_q;
  assign goal_out        = goal_q;
  assign score_p1_out    = score_p1_q;
  assign score_p2_out    = score_p2_q;

endmodule

// File: tb/tb_puck_ctl.sv
// tb_puck_ctl: frame-level bench for puck_ctl with a behavioural physics model.
module tb_puck_ctl;

  localparam int R    = 16;
  localparam int XMAX = 1024 - 1 - R;
  localparam int YMAX = 768 - 1 - R;
`ifdef GOAL_DETECT_EN
  localparam bit GOAL_ON = 1'b1;
`else
  localparam bit GOAL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic [11:0] p1x, p1y, p2x, p2y;
  logic [7:0]  p1r, p2r;
  logic [11:0] px_o, py_o;
  logic [7:0]  pr_o;
  logic        busy_o, hit_o, goal_o;
  logic [3:0]  s1_o, s2_o;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;

  // Model state: position, velocity, friction phase, scores
  int mx, my, mvx, mvy, mfc, ms1, ms2;
  int exp_hit, exp_goal;
  int obs_hits, obs_goals, obs_tmo;

  always #5 clk = ~clk;

  puck_ctl dut (
    .clk_in          (clk),
    .rst             (rst),
    .vblnk_in        (vblnk),
    .p1_xpos_in      (p1x),
    .p1_ypos_in      (p1y),
    .p1_radius_in    (p1r),
    .p2_xpos_in      (p2x),
    .p2_ypos_in      (p2y),
    .p2_radius_in    (p2r),
    .puck_xpos_out   (px_o),
    .puck_ypos_out   (py_o),
    .puck_radius_out (pr_o),
    .busy_out        (busy_o),
    .hit_out         (hit_o),
    .goal_out        (goal_o),
    .score_p1_out    (s1_o),
    .score_p2_out    (s2_o)
  );

  function automatic int clip12(int v);
    return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
  endfunction

  function automatic int hitv(int d, int v);
    if (d > 0) return 6;
    if (d < 0) return -6;
    return (v < 0) ? -6 : 6;
  endfunction

  function automatic int sgn(int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    mx = 512; my = 384; mvx = 0; mvy = 0; mfc = 0; ms1 = 0; ms2 = 0;
  endtask

  // One frame of puck physics computed directly from the game rules
  task automatic model_frame(input int ax, ay, ar, bx, by, br);
    int d1, d2, t1, t2;
    exp_hit = 0; exp_goal = 0;
    d1 = (mx - ax) * (mx - ax) + (my - ay) * (my - ay);
    d2 = (mx - bx) * (mx - bx) + (my - by) * (my - by);
    t1 = (ar + R) * (ar + R);
    t2 = (br + R) * (br + R);
    if (d1 <= t1) begin
      mvx = hitv(mx - ax, mvx); mvy = hitv(my - ay, mvy); exp_hit = 1;
    end else if (d2 <= t2) begin
      mvx = hitv(mx - bx, mvx); mvy = hitv(my - by, mvy); exp_hit = 1;
    end
    if (exp_hit == 0) begin
      mfc = (mfc + 1) % 16;
      if (mfc == 0) begin
        mvx = mvx - sgn(mvx); mvy = mvy - sgn(mvy);
      end
    end
    mx = mx + mvx; my = my + mvy;
    if (GOAL_ON && (mx < R || mx > XMAX) && my >= 284 && my <= 484) begin
      if (mx < R) ms2 = (ms2 < 9) ? ms2 + 1 : 9;
      else        ms1 = (ms1 < 9) ? ms1 + 1 : 9;
      mx = 512; my = 384; mvx = 0; mvy = 0; exp_goal = 1;
    end else begin
      if (mx < R) begin mx = R; mvx = iabs(mvx); end
      else if (mx > XMAX) begin mx = XMAX; mvx = -iabs(mvx); end
      if (my < R) begin my = R; mvy = iabs(mvy); end
      else if (my > YMAX) begin my = YMAX; mvy = -iabs(mvy); end
    end
  endtask

  // Drive players, raise vblank, collect pulses until busy drops (bounded)
  task automatic run_frame(input int ax, ay, ar, bx, by, br);
    bit started;
    @(negedge clk);
    p1x = 12'(clip12(ax)); p1y = 12'(clip12(ay)); p1r = 8'(ar);
    p2x = 12'(clip12(bx)); p2y = 12'(clip12(by)); p2r = 8'(br);
    vblnk = 1'b1;
    obs_hits = 0; obs_goals = 0; obs_tmo = 1; started = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (hit_o)  obs_hits++;
      if (goal_o) obs_goals++;
      if (busy_o) started = 1'b1;
      else if (started) begin obs_tmo = 0; break; end
    end
    @(negedge clk); vblnk = 1'b0;
    @(negedge clk);
    frame_no++;
    $display("frame %0d p1=(%0d,%0d,%0d) p2=(%0d,%0d,%0d) puck=(%0d,%0d) hits=%0d goals=%0d score=%0d:%0d",
             frame_no, p1x, p1y, p1r, p2x, p2y, p2r, px_o, py_o, obs_hits, obs_goals, s1_o, s2_o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vblnk = 1'b0;
    p1x = 12'd40; p1y = 12'd40; p1r = 8'd8;
    p2x = 12'd40; p2y = 12'd730; p2r = 8'd8;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if ({px_o, py_o} !== {12'd512, 12'd384}) begin n_fail++; $display("FAIL reset_pos: got (%0d,%0d) expected (512,384)", px_o, py_o); end
    n_checks++; if (pr_o !== 8'd16) begin n_fail++; $display("FAIL reset_radius: got %0d expected 16", pr_o); end
    n_checks++; if ({busy_o, hit_o, goal_o} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy_o, hit_o, goal_o}); end
    n_checks++; if ({s1_o, s2_o} !== 8'h00) begin n_fail++; $display("FAIL reset_scores: got %0d:%0d expected 0:0", s1_o, s2_o); end
  endtask

  task automatic test_far_frames();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      model_frame(40, 40, 8, 40, 730, 8);
      run_frame(40, 40, 8, 40, 730, 8);
      n_checks++; if ({px_o, py_o} !== {12'd512, 12'd384}) begin n_fail++; $display("FAIL far_pos: got (%0d,%0d) expected (512,384)", px_o, py_o); end
      n_checks++; if (obs_hits !== 0 || obs_tmo !== 0) begin n_fail++; $display("FAIL far_hits: got hits=%0d tmo=%0d expected hits=0 tmo=0", obs_hits, obs_tmo); end
    end
  endtask

  task automatic test_p1_hit();
    do_reset();
    model_frame(480, 384, 20, 40, 730, 8);
    run_frame(480, 384, 20, 40, 730, 8);
    n_checks++; if ({px_o, py_o} !== {12'd518, 12'd390}) begin n_fail++; $display("FAIL p1_hit_pos: got (%0d,%0d) expected (518,390)", px_o, py_o); end
    n_checks++; if (obs_hits !== 1 || obs_tmo !== 0) begin n_fail++; $display("FAIL p1_hit_pulse: got hits=%0d tmo=%0d expected hits=1 tmo=0", obs_hits, obs_tmo); end
  endtask

  task automatic test_both_hit();
    do_reset();
    model_frame(492, 394, 30, 532, 374, 30);
    run_frame(492, 394, 30, 532, 374, 30);
    n_checks++; if ({px_o, py_o} !== {12'd518, 12'd378}) begin n_fail++; $display("FAIL both_hit_pos: got (%0d,%0d) expected (518,378)", px_o, py_o); end
    n_checks++; if (obs_hits !== 1) begin n_fail++; $display("FAIL both_hit_pulse: got hits=%0d expected 1", obs_hits); end
  endtask

  task automatic test_friction();
    do_reset();
    model_frame(480, 384, 20, 40, 730, 8);
    run_frame(480, 384, 20, 40, 730, 8);
    for (int f = 1; f <= 106; f++) begin
      model_frame(40, 40, 8, 40, 730, 8);
      run_frame(40, 40, 8, 40, 730, 8);
      n_checks++; if ({px_o, py_o} !== {12'(mx), 12'(my)} || obs_hits !== 0) begin n_fail++; $display("FAIL fric_frame %0d: got (%0d,%0d) hits=%0d expected (%0d,%0d) hits=0", f, px_o, py_o, obs_hits, mx, my); end
      if (f == 16) begin
        n_checks++; if ({px_o, py_o} !== {12'd613, 12'd485}) begin n_fail++; $display("FAIL fric_first_step: got (%0d,%0d) expected (613,485)", px_o, py_o); end
      end
    end
    n_checks++; if ({px_o, py_o} !== {12'd848, 12'd720}) begin n_fail++; $display("FAIL fric_rest: got (%0d,%0d) expected (848,720)", px_o, py_o); end
  endtask

  task automatic test_wall_push();
    bit seen_xmax, seen_ymax;
    do_reset();
    seen_xmax = 1'b0; seen_ymax = 1'b0;
    for (int f = 0; f < 120; f++) begin
      int ax, ay;
      ax = mx - 20; ay = my;
      model_frame(ax, ay, 20, 40, 730, 8);
      run_frame(ax, ay, 20, 40, 730, 8);
      if (px_o == 12'(XMAX)) seen_xmax = 1'b1;
      if (py_o == 12'(YMAX)) seen_ymax = 1'b1;
      n_checks++; if ({px_o, py_o} !== {12'(mx), 12'(my)}) begin n_fail++; $display("FAIL wall_pos frame %0d: got (%0d,%0d) expected (%0d,%0d)", f, px_o, py_o, mx, my); end
      n_checks++; if (obs_hits !== exp_hit || obs_tmo !== 0) begin n_fail++; $display("FAIL wall_pulse frame %0d: got hits=%0d tmo=%0d expected hits=%0d tmo=0", f, obs_hits, obs_tmo, exp_hit); end
    end
    n_checks++; if ({seen_xmax, seen_ymax} !== 2'b11) begin n_fail++; $display("FAIL wall_clamp_seen: got %b expected 11", {seen_xmax, seen_ymax}); end
  endtask

  task automatic test_left_push();
    do_reset();
    for (int f = 0; f < 120; f++) begin
      int ax, ay;
      ax = mx + 20; ay = ((f % 2) == 0) ? my + 1 : my - 1;
      model_frame(ax, ay, 20, 40, 730, 8);
      run_frame(ax, ay, 20, 40, 730, 8);
      n_checks++; if ({px_o, py_o} !== {12'(mx), 12'(my)}) begin n_fail++; $display("FAIL left_pos frame %0d: got (%0d,%0d) expected (%0d,%0d)", f, px_o, py_o, mx, my); end
      n_checks++; if (obs_goals !== exp_goal || obs_hits !== exp_hit) begin n_fail++; $display("FAIL left_pulse frame %0d: got hits=%0d goals=%0d expected hits=%0d goals=%0d", f, obs_hits, obs_goals, exp_hit, exp_goal); end
      n_checks++; if ({s1_o, s2_o} !== {4'(ms1), 4'(ms2)}) begin n_fail++; $display("FAIL left_score frame %0d: got %0d:%0d expected %0d:%0d", f, s1_o, s2_o, ms1, ms2); end
    end
    n_checks++; if (s2_o !== (GOAL_ON ? 4'd1 : 4'd0)) begin n_fail++; $display("FAIL left_goal_total: got %0d expected %0d", s2_o, GOAL_ON ? 1 : 0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 150; f++) begin
      int ax, ay, ar, bx, by, br;
      ar = int'($urandom_range(0, 48)); br = int'($urandom_range(0, 48));
      if ($urandom_range(0, 2) == 0) begin
        ax = mx + int'($urandom_range(0, 80)) - 40; ay = my + int'($urandom_range(0, 80)) - 40;
      end else begin
        ax = int'($urandom_range(0, 4095)); ay = int'($urandom_range(0, 4095));
      end
      if ($urandom_range(0, 2) == 0) begin
        bx = mx + int'($urandom_range(0, 80)) - 40; by = my + int'($urandom_range(0, 80)) - 40;
      end else begin
        bx = int'($urandom_range(0, 1023)); by = int'($urandom_range(0, 767));
      end
      ax = clip12(ax); ay = clip12(ay); bx = clip12(bx); by = clip12(by);
      model_frame(ax, ay, ar, bx, by, br);
      run_frame(ax, ay, ar, bx, by, br);
      n_checks++; if ({px_o, py_o} !== {12'(mx), 12'(my)}) begin n_fail++; $display("FAIL rand_pos frame %0d: got (%0d,%0d) expected (%0d,%0d)", f, px_o, py_o, mx, my); end
      n_checks++; if (obs_hits !== exp_hit || obs_goals !== exp_goal || obs_tmo !== 0) begin n_fail++; $display("FAIL rand_pulse frame %0d: got hits=%0d goals=%0d tmo=%0d expected hits=%0d goals=%0d tmo=0", f, obs_hits, obs_goals, obs_tmo, exp_hit, exp_goal); end
      n_checks++; if ({s1_o, s2_o} !== {4'(ms1), 4'(ms2)}) begin n_fail++; $display("FAIL rand_score frame %0d: got %0d:%0d expected %0d:%0d", f, s1_o, s2_o, ms1, ms2); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    model_frame(480, 384, 20, 40, 730, 8);
    run_frame(480, 384, 20, 40, 730, 8);
    n_checks++; if (px_o !== 12'd518) begin n_fail++; $display("FAIL midrst_pre: got x=%0d expected 518", px_o); end
    @(negedge clk); vblnk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b expected 1", busy_o); end
    @(negedge clk); rst = 1'b1; vblnk = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({px_o, py_o} !== {12'd512, 12'd384}) begin n_fail++; $display("FAIL midrst_pos: got (%0d,%0d) expected (512,384)", px_o, py_o); end
    n_checks++; if ({busy_o, hit_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b expected 00", {busy_o, hit_o}); end
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int f = 0; f < 2; f++) begin
      model_frame(40, 40, 8, 40, 730, 8);
      run_frame(40, 40, 8, 40, 730, 8);
      n_checks++; if ({px_o, py_o} !== {12'd512, 12'd384}) begin n_fail++; $display("FAIL midrst_after: got (%0d,%0d) expected (512,384)", px_o, py_o); end
    end
  endtask

  initial begin
    rst = 1'b1; vblnk = 1'b0;
    p1x = '0; p1y = '0; p1r = '0; p2x = '0; p2y = '0; p2r = '0;
    model_reset();
    test_reset();
    test_far_frames();
    test_p1_hit();
    test_both_hit();
    test_friction();
    test_wall_push();
    test_left_push();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
